// File: rtl/hex_scan_driver_pkg.sv
// rtl/hex_scan_driver_pkg.sv - shared constants and blanking helper for the hex scan driver
package hex_scan_driver_pkg;

  localparam int NUM_DIGITS      = 4;
  localparam int IDX_W           = $clog2(NUM_DIGITS);
  localparam int CLK_DIV_DEFAULT = 50000;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Digit 0 is never leading-zero blanked, so 0x0000 still shows one "0".
  function automatic logic isBlanked(input logic [15:0] disp, input logic [IDX_W-1:0] idx,
                                     input logic blankLz, input logic enable);
    logic [15:0] upper;
    upper = disp >> {idx, 2'b00};
    if (!enable) return 1'b1;
    return blankLz && (idx != '0) && (upper == 16'h0000);
  endfunction

endpackage

// File: rtl/hex_scan_driver_if.sv
// rtl/hex_scan_driver_if.sv - valid/ready load channel carrying a four-nibble display value
interface hex_scan_driver_if;

  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/hex_scan_driver_prescaler.sv
// rtl/hex_scan_driver_prescaler.sv - digit slot prescaler, one tick every CLK_DIV enabled clocks
module scan_prescaler
  import hex_scan_driver_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == CNT_W'(CLK_DIV - 1));

  // en low holds the count so a paused slot resumes where it left off.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - multiplexed four-digit hex display scanner with double-buffered load
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  blank_lz,
  hex_scan_driver_if.slave      loadIf,
  output logic [3:0]            digit_nibble,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_done
);

  logic             tick;
  logic             frameTick;
  logic [IDX_W-1:0] idx;
  logic [15:0]      display;
  logic [15:0]      pending;
  logic             pendingValid;

  scan_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign frameTick         = tick && (idx == LAST_IDX);
  assign loadIf.load_ready = !pendingValid;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      if (tick) idx <= idx + IDX_W'(1);
      frame_done <= frameTick;
    end
  end

  // Promotion and acceptance are exclusive: promotion needs a full pending
  // slot, acceptance an empty one, so a load taken on the boundary waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      display      <= 16'h0000;
      pending      <= 16'h0000;
      pendingValid <= 1'b0;
    end else if (frameTick && pendingValid) begin
      display      <= pending;
      pendingValid <= 1'b0;
    end else if (loadIf.load_valid && !pendingValid) begin
      pending      <= loadIf.load_data;
      pendingValid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_nibble <= 4'h0;
      an_n         <= 4'b1110;
    end else begin
      digit_nibble <= display[{idx, 2'b00} +: 4];
      an_n         <= isBlanked(display, idx, blank_lz, en) ? AN_OFF : ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb/tb_hex_scan_driver.sv - randomized self-checking bench against a slot-arithmetic display model
module tb_hex_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       blank_lz = 1'b0;
  logic [3:0] digit_nibble;
  logic [3:0] an_n;
  logic       frame_done;

  hex_scan_driver_if lif ();

  hex_scan_driver #(
    .CLK_DIV(DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .blank_lz    (blank_lz),
    .loadIf      (lif),
    .digit_nibble(digit_nibble),
    .an_n        (an_n),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: position in the scan is just the number of enabled clocks since reset.
  int          enCycles = 0;
  logic [15:0] mDisplay = '0;
  logic [15:0] mPending = '0;
  bit          mPendValid = 0;
  logic        expReady;
  logic [3:0]  expNibble;
  logic [3:0]  expAn;
  logic        expFrame;

  task automatic step();
    int   curIdx;
    bit   tick;
    bit   blank;
    logic [15:0] upper;
    if (rst) begin
      enCycles   = 0;
      mDisplay   = '0;
      mPending   = '0;
      mPendValid = 0;
      expNibble  = 4'h0;
      expAn      = 4'b1110;
      expFrame   = 1'b0;
    end else begin
      curIdx    = (enCycles / DIV) % 4;
      tick      = en && ((enCycles % DIV) == DIV - 1);
      upper     = mDisplay >> (4 * curIdx);
      expNibble = upper[3:0];
      blank     = !en || (blank_lz && curIdx > 0 && upper == 16'h0000);
      expAn     = blank ? 4'b1111 : ~(4'b0001 << curIdx);
      expFrame  = tick && curIdx == 3;
      if (expFrame && mPendValid) begin
        mDisplay   = mPending;
        mPendValid = 0;
      end else if (lif.load_valid && !mPendValid) begin
        mPending   = lif.load_data;
        mPendValid = 1;
      end
      if (en) enCycles = (enCycles + 1) % FRAME;
    end
    expReady = !mPendValid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    lif.load_valid = 1'b1;
    lif.load_data = 16'hFFFF;
    step();
    checks++;
    if ({lif.load_ready, digit_nibble, an_n, frame_done} !== {1'b1, 4'h0, 4'b1110, 1'b0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b nib=%h an=%b fd=%b want rdy=1 nib=0 an=1110 fd=0",
               lif.load_ready, digit_nibble, an_n, frame_done);
    end
    rst = 1'b0;
    en = 1'b0;
    lif.load_valid = 1'b0;
    step();
    checks++;
    if ({lif.load_ready, digit_nibble, an_n, frame_done} !== {1'b1, 4'h0, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle_en0: got rdy=%b nib=%h an=%b fd=%b want rdy=1 nib=0 an=1111 fd=0",
               lif.load_ready, digit_nibble, an_n, frame_done);
    end
  endtask

  task automatic test_idle_scan();
    int pulses = 0;
    en = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_done === 1'b1) pulses++;
      checks++;
      if ({lif.load_ready, digit_nibble, an_n, frame_done} !== {expReady, expNibble, expAn, expFrame}) begin
        errors++;
        $display("FAIL idle_scan cyc %0d: got rdy=%b nib=%h an=%b fd=%b exp rdy=%b nib=%h an=%b fd=%b",
                 i, lif.load_ready, digit_nibble, an_n, frame_done, expReady, expNibble, expAn, expFrame);
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL idle_frame_count: got %0d pulses want 3", pulses);
    end
  endtask

  task automatic test_load(input logic [15:0] value, input logic lz, input string name);
    blank_lz = lz;
    lif.load_valid = 1'b1;
    lif.load_data = value;
    step();
    lif.load_valid = 1'b0;
    checks++;
    if (lif.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_drop: got %b want 0", name, lif.load_ready);
    end
    for (int i = 0; i < 2 * FRAME + 3; i++) begin
      step();
      checks++;
      if ({lif.load_ready, digit_nibble, an_n, frame_done} !== {expReady, expNibble, expAn, expFrame}) begin
        errors++;
        $display("FAIL %s cyc %0d: got rdy=%b nib=%h an=%b fd=%b exp rdy=%b nib=%h an=%b fd=%b",
                 name, i, lif.load_ready, digit_nibble, an_n, frame_done, expReady, expNibble, expAn, expFrame);
      end
    end
  endtask

  task automatic test_back_to_back();
    lif.load_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      lif.load_data = 16'($urandom);
      step();
      checks++;
      if ({lif.load_ready, digit_nibble, an_n, frame_done} !== {expReady, expNibble, expAn, expFrame}) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got rdy=%b nib=%h an=%b fd=%b exp rdy=%b nib=%h an=%b fd=%b",
                 i, lif.load_ready, digit_nibble, an_n, frame_done, expReady, expNibble, expAn, expFrame);
      end
    end
    lif.load_valid = 1'b0;
  endtask

  task automatic test_boundary_load();
    int guard = 0;
    en = 1'b1;
    while (!(enCycles == FRAME - 1 && !mPendValid) && guard < 10 * FRAME) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 10 * FRAME) begin
      errors++;
      $display("FAIL boundary_align: no boundary slot within %0d cycles", guard);
    end
    lif.load_valid = 1'b1;
    lif.load_data = 16'($urandom) | 16'h1000;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step();
      lif.load_valid = 1'b0;
      checks++;
      if ({lif.load_ready, digit_nibble, an_n, frame_done} !== {expReady, expNibble, expAn, expFrame}) begin
        errors++;
        $display("FAIL boundary_load cyc %0d: got rdy=%b nib=%h an=%b fd=%b exp rdy=%b nib=%h an=%b fd=%b",
                 i, lif.load_ready, digit_nibble, an_n, frame_done, expReady, expNibble, expAn, expFrame);
      end
    end
  endtask

  task automatic test_reset_pending();
    lif.load_valid = 1'b1;
    lif.load_data = 16'hBEEF;
    step();
    lif.load_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({lif.load_ready, digit_nibble, an_n, frame_done} !== {1'b1, 4'h0, 4'b1110, 1'b0}) begin
      errors++;
      $display("FAIL reset_pending: got rdy=%b nib=%h an=%b fd=%b want rdy=1 nib=0 an=1110 fd=0",
               lif.load_ready, digit_nibble, an_n, frame_done);
    end
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step();
      checks++;
      if ({lif.load_ready, digit_nibble, an_n, frame_done} !== {expReady, expNibble, expAn, expFrame}) begin
        errors++;
        $display("FAIL reset_pending_after cyc %0d: got rdy=%b nib=%h an=%b fd=%b exp rdy=%b nib=%h an=%b fd=%b",
                 i, lif.load_ready, digit_nibble, an_n, frame_done, expReady, expNibble, expAn, expFrame);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      en = ($urandom_range(0, 7) != 0);
      blank_lz = $urandom_range(0, 1);
      rst = ($urandom_range(0, 99) == 0);
      lif.load_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: lif.load_data = 16'($urandom_range(0, 15));
        1: lif.load_data = 16'($urandom_range(0, 255)) << 4;
        default: lif.load_data = 16'($urandom);
      endcase
      step();
      checks++;
      if ({lif.load_ready, digit_nibble, an_n, frame_done} !== {expReady, expNibble, expAn, expFrame}) begin
        errors++;
        $display("FAIL random cyc %0d: got rdy=%b nib=%h an=%b fd=%b exp rdy=%b nib=%h an=%b fd=%b",
                 i, lif.load_ready, digit_nibble, an_n, frame_done, expReady, expNibble, expAn, expFrame);
      end
    end
    rst = 1'b0;
    lif.load_valid = 1'b0;
  endtask

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data = 16'h0000;
    test_reset();
    test_idle_scan();
    test_load(16'h1A2F, 1'b0, "load_1a2f");
    test_load(16'h00B0, 1'b1, "blank_00b0");
    test_load(16'h0000, 1'b1, "blank_zero");
    test_load(16'h0C00, 1'b1, "blank_0c00");
    test_back_to_back();
    test_boundary_load();
    test_boundary_load();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 Parameter: CLK_DIV, default 50000, clocks per digit slot; SHALL be >= 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: en  input  1  scan enable; 0 freezes prescaler and digit index and blanks all anodes.
REQ-005 Port: blank_lz  input  1  1 enables leading-zero blanking.
REQ-006 Port: load_valid  input  1  new display value offered.
REQ-007 Port: load_data  input  16  four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-008 Port: load_ready  output  1  1 when a pending slot is free.
REQ-009 Port: digit_nibble  output  4  nibble of the active digit; feeds the downstream seven-segment decoder input.
REQ-010 Port: an_n  output  4  active-low one-hot anode select; bit i drives digit i.
REQ-011 Port: frame_done  output  1  one-cycle pulse when the index wraps from 3 to 0.

Function
REQ-012 The prescaler SHALL count 0..CLK_DIV-1 while en=1 and assert tick in the cycle where count = CLK_DIV-1, then return to 0.
REQ-013 On tick, the digit index SHALL advance 0->1->2->3->0; the index SHALL NOT change without tick.
REQ-014 frame_done SHALL be 1 for exactly the cycle following a tick taken at index 3, i.e. the first cycle with index 0.
REQ-015 Load handshake: transfer occurs when load_valid=1 and load_ready=1; load_data SHALL be captured into the pending register with pending_valid set.
REQ-016 load_ready SHALL equal NOT pending_valid; load_valid with load_ready=0 SHALL be ignored, and the offer SHALL NOT be stored.
REQ-017 On a tick at index 3 with pending_valid=1, the display register SHALL take the pending value and pending_valid SHALL clear in that same edge.
REQ-018 A load accepted in the same cycle as a frame-boundary tick SHALL NOT be displayed in that frame; it SHALL be promoted at the next frame boundary.
REQ-019 digit_nibble SHALL equal display[4*idx+3 : 4*idx], registered, updated on the edge after the index changes (one-cycle latency from index to outputs).
REQ-020 an_n SHALL be registered and consistent with digit_nibble: 4'b1111 with only bit idx cleared, unless blanked.
REQ-021 Digit idx is blanked (an_n = 4'b1111) when en=0, or when blank_lz=1, idx>0, and every nibble idx..3 of display is zero.
REQ-022 Digit 0 SHALL never be blanked by leading-zero logic; a display value of 0x0000 shows a single "0".
REQ-023 Deasserting en mid-slot SHALL hold count and idx; reasserting SHALL resume from the held count. The load handshake SHALL remain operative while en=0, and promotion SHALL wait for a frame-boundary tick.

Reset
REQ-024 With rst=1 at an edge: count=0, idx=0, display=16'h0000, pending_valid=0, pending=0.
REQ-025 Output values after reset: load_ready=1, digit_nibble=4'h0, an_n=4'b1110, frame_done=0.
REQ-026 rst SHALL take priority over load, tick, and en in the same cycle; a pending value present at reset SHALL be discarded.

Structure
REQ-027 A shared package SHALL hold NUM_DIGITS=4, the CLK_DIV default, and AN_OFF=4'b1111; the package SHALL NOT hold per-instance state.
REQ-028 The prescaler SHALL be one sub-module, scan_prescaler (inputs clk, rst, en; output tick; parameter CLK_DIV); all other logic SHALL be inline.

Verification (CLK_DIV=4 unless stated)
REQ-029 Reset, then en=1 with no load -> an_n cycles 1110,1110(blanking off),1101,1011,0111 at 4-clock spacing; digit_nibble=0 throughout; frame_done pulses every 16 clocks.
REQ-030 Load 16'h1A2F while idle -> load_ready drops the next cycle; after the next frame boundary, digits 0..3 show F,2,A,1; load_ready returns to 1 at the boundary.
REQ-031 blank_lz=1 with display 16'h00B0 -> an_n for idx 2,3 = 1111; idx 1 shows B; idx 0 shows 0 (not blanked).
REQ-032 Second load_valid while pending_valid=1 -> ignored; the first value is displayed, then the second is accepted only after load_ready rises.
REQ-033 Load accepted exactly on the index-3 tick -> old display persists for one more full frame before the new value appears.
REQ-034 rst pulsed mid-frame with a load pending -> outputs match REQ-025 the next cycle; the pending value is never displayed.
